cn_host_bridge: RTL
===================

CN_HOST_BRIDGE -- requirements
Module: cn_host_bridge

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 19, per-core memory address width; RD_LATENCY, default 3, cycles from read issue to rddata valid at the downstream ports; RSP_DEPTH, default 4, response FIFO entries.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  bridge accepts request this cycle
- req_is_mem  in  1  1 = memory space, 0 = register space
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH+2  request address
- req_wdata  in  128  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  128  read data
- reg_address  out  14  downstream register address
- reg_write  out  1  downstream register write strobe
- reg_wrdata  out  32  downstream register write data
- reg_rddata  in  32  downstream register read data
- mem_address  out  ADDR_WIDTH+2  downstream memory address
- mem_write  out  1  downstream memory write strobe
- mem_wrdata  out  128  downstream memory write data
- mem_rddata  in  128  downstream memory read data

Function
REQ-003 SHALL accept a request when req_valid && req_ready are both high on a rising edge.
REQ-004 SHALL drive downstream outputs from registers, updated in the cycle after acceptance (issue cycle T).
REQ-005 SHALL assert, for one cycle only, mem_write at T for an accepted memory write, or reg_write at T for an accepted register write. Write strobes SHALL be 0 in every other cycle.
REQ-006 SHALL drive reg_address = req_addr[13:0] and reg_wrdata = req_wdata[31:0] for register requests, and mem_address = req_addr and mem_wrdata = req_wdata for memory requests. A downstream field SHALL hold its last value when not updated.
REQ-007 SHALL issue reads with both write strobes low, and SHALL sample reg_rddata or mem_rddata (selected by req_is_mem) at T+RD_LATENCY.
REQ-008 SHALL track in-flight reads in a RD_LATENCY-deep valid/space shift register.
REQ-009 SHALL zero-extend register read data to 128 bits.
REQ-010 SHALL push each sampled read into the response FIFO, so responses return in request order.
REQ-011 SHALL accept back-to-back requests, one per cycle, of any mix of reads and writes.
REQ-012 SHALL define outstanding = in-flight reads + FIFO occupancy, and SHALL set req_ready = (outstanding < RSP_DEPTH), registered and independent of req_write.
REQ-013 SHALL guarantee that the FIFO never overflows, including when a response push and a host pop occur in the same cycle.
REQ-014 SHALL drive rsp_valid = FIFO not empty, with rsp_data at the FIFO head, and SHALL pop on rsp_valid && rsp_ready.
REQ-015 SHALL hold rsp_data stable while rsp_valid && !rsp_ready.
REQ-016 SHALL, on simultaneous push and pop, leave occupancy unchanged. Push into an empty FIFO SHALL make rsp_valid high on the next cycle.
REQ-017 SHALL wrap the FIFO read and write pointers modulo RSP_DEPTH.
REQ-018 SHALL, when an accepted write and an in-flight read sample coincide, perform both without interference.

Reset
REQ-019 SHALL, while reset_n is low at a clock edge, drive req_ready=0, rsp_valid=0, rsp_data=0, reg_write=0, mem_write=0, reg_address=0, reg_wrdata=0, mem_address=0 and mem_wrdata=0.
REQ-020 SHALL, on reset, clear the in-flight shift register and FIFO pointers, discarding pending reads mid-operation.
REQ-021 SHALL assert req_ready in the first cycle after reset_n returns high.

Structure
REQ-022 SHALL place the space encoding (MEM/REG), the 14-bit register-address width and the 128-bit data width in the shared cn package header.
REQ-023 SHALL implement the response FIFO as sub-module cn_rsp_fifo, parameterised by depth and width.

Verification
REQ-024 The bench SHALL cover a register write: req addr 0x0404, wdata 0xDEADBEEF -> one-cycle reg_write, reg_address 0x0404, reg_wrdata 0xDEADBEEF, and no response.
REQ-025 The bench SHALL cover a memory read: model returns 0x1122..FF at T+3 -> rsp_valid with that 128-bit data, at most 5 cycles after acceptance.
REQ-026 The bench SHALL cover a register read returning 0x0000ABCD -> rsp_data = 0x0...0000ABCD.
REQ-027 The bench SHALL cover 6 back-to-back reads with rsp_ready=0 -> exactly 4 accepted, then req_ready=0. Raising rsp_ready SHALL yield 4 in-order responses, after which the remaining 2 are accepted.
REQ-028 The bench SHALL cover interleaved write, read, write, read with rsp_ready=1 -> strobes at the correct T, and 2 responses in order.
REQ-029 The bench SHALL cover reset_n pulsed low with 2 reads in flight -> no rsp_valid afterwards, and all outputs at their reset values.

Source files
------------

// File: rtl/cn_pkg.sv
// Shared definitions for the cn host bridge: address-space encoding,
// register-port geometry and the common response data width.
package cn_pkg;

    typedef enum logic {
        SPACE_REG = 1'b0,
        SPACE_MEM = 1'b1
    } cn_space_e;

    localparam int REG_ADDR_W = 14;
    localparam int REG_DATA_W = 32;
    localparam int DATA_W     = 128;

    // Widen a 32-bit register read to the response data width.
    function automatic logic [DATA_W-1:0] zext_reg(input logic [REG_DATA_W-1:0] d);
        return {{(DATA_W-REG_DATA_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/cn_rsp_fifo.sv
// Response FIFO with registered valid/head outputs. The head register is
// refreshed every cycle, so it stays stable while the host stalls.
module cn_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic [PW-1:0]    wr_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_after_pop;
    logic [CW-1:0]    count_next;
    logic             do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Next-state pointers and occupancy.
    always_comb begin
        do_pop          = pop && (count != {CW{1'b0}});
        rd_next         = do_pop ? wrap_inc(rd_ptr) : rd_ptr;
        wr_next         = push ? wrap_inc(wr_ptr) : wr_ptr;
        count_after_pop = count - CW'(do_pop);
        count_next      = count_after_pop + CW'(push);
    end

    // Storage array; contents need no reset since valid gates them.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head/valid outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= {PW{1'b0}};
            wr_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
            valid  <= 1'b0;
            head   <= {WIDTH{1'b0}};
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            count  <= count_next;
            valid  <= (count_next != {CW{1'b0}});
            if (count_after_pop == {CW{1'b0}}) begin
                // Only the incoming entry (if any) can become the head.
                if (push) begin
                    head <= push_data;
                end
            end else begin
                head <= store[rd_next];
            end
        end
    end

endmodule

// File: rtl/cn_host_bridge.sv
// Host bridge: forwards host requests to a register port or a memory port,
// times reads by a fixed downstream latency and returns read data in order
// through a response FIFO. Flow control admits a request only while the
// reads already accepted still fit in the FIFO.
module cn_host_bridge
    import cn_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int RD_LATENCY = 3,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_mem,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [REG_ADDR_W-1:0]   reg_address,
    output logic                    reg_write,
    output logic [REG_DATA_W-1:0]   reg_wrdata,
    input  logic [REG_DATA_W-1:0]   reg_rddata,
    output logic [ADDR_WIDTH+1:0]   mem_address,
    output logic                    mem_write,
    output logic [DATA_W-1:0]       mem_wrdata,
    input  logic [DATA_W-1:0]       mem_rddata
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                  accept;
    logic                  accept_rd;
    logic                  pop;
    logic                  push;
    logic [DATA_W-1:0]     push_data;
    logic                  rd_issue;
    logic                  rd_issue_space;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY-1:0] space_sr;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         outstanding_next;

    // Handshakes, read-sample selection and outstanding-read bookkeeping.
    always_comb begin
        accept    = req_valid && req_ready;
        accept_rd = accept && !req_write;
        pop       = rsp_valid && rsp_ready;
        push      = vld_sr[RD_LATENCY-1];
        if (space_sr[RD_LATENCY-1] == SPACE_MEM) begin
            push_data = mem_rddata;
        end else begin
            push_data = zext_reg(reg_rddata);
        end
        outstanding_next = outstanding + CW'(accept_rd) - CW'(pop);
    end

    // Downstream strobes and fields; fields hold until their space is used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_write   <= 1'b0;
            reg_write   <= 1'b0;
            mem_address <= {(ADDR_WIDTH+2){1'b0}};
            mem_wrdata  <= {DATA_W{1'b0}};
            reg_address <= {REG_ADDR_W{1'b0}};
            reg_wrdata  <= {REG_DATA_W{1'b0}};
        end else begin
            mem_write <= accept && req_write && (req_is_mem == SPACE_MEM);
            reg_write <= accept && req_write && (req_is_mem == SPACE_REG);
            if (accept && (req_is_mem == SPACE_MEM)) begin
                mem_address <= req_addr;
                mem_wrdata  <= req_wdata;
            end
            if (accept && (req_is_mem == SPACE_REG)) begin
                reg_address <= req_addr[REG_ADDR_W-1:0];
                reg_wrdata  <= req_wdata[REG_DATA_W-1:0];
            end
        end
    end

    // In-flight read tracker: issue stage, then one bit per latency cycle,
    // so the last stage lines up with the cycle the read data is valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_issue       <= 1'b0;
            rd_issue_space <= 1'b0;
            vld_sr         <= {RD_LATENCY{1'b0}};
            space_sr       <= {RD_LATENCY{1'b0}};
        end else begin
            rd_issue       <= accept_rd;
            rd_issue_space <= req_is_mem;
            vld_sr[0]      <= rd_issue;
            space_sr[0]    <= rd_issue_space;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                space_sr[i] <= space_sr[i-1];
            end
        end
    end

    // Outstanding reads (in flight plus queued) and the registered ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outstanding <= {CW{1'b0}};
            req_ready   <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            req_ready   <= (outstanding_next < CW'(RSP_DEPTH));
        end
    end

    cn_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .valid     (rsp_valid),
        .head      (rsp_data)
    );

endmodule
